// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle MIPS datapath: select-error policies
// and the default datapath and register-address widths.
package cpu_pkg;

  // Select-error policy for operand_sel_reg.
  localparam int SEL_PRIORITY = 0;  // multi-hot resolves to the lowest index
  localparam int SEL_STRICT   = 1;  // multi-hot is rejected, register holds

  // Default datapath width and GPR address width. The GPR write-register mux
  // is an operand_sel_reg with WIDTH = REG_ADDR_W.
  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic {
    POL_PRIORITY = 1'b0,
    POL_STRICT   = 1'b1
  } sel_policy_e;

endpackage

// File: rtl/onehot_prio_enc.sv
// Lowest-index priority encoder for one-hot selects. Also flags an empty
// select (hit = 0) and a select with more than one bit set (multi = 1).
// Shared with the control-unit decoders.
module onehot_prio_enc #(
  parameter int N = 5
) (
  input  logic [N-1:0]         sel,
  output logic [$clog2(N)-1:0] idx,
  output logic                 hit,
  output logic                 multi
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (sel[i]) idx = ($clog2(N))'(i);
    end
  end

  assign hit = |sel;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi = |(sel & (sel - N'(1)));

endmodule

// File: rtl/operand_sel_reg.sv
// One-hot operand mux with an explicit hold register. The selected source is
// presented combinationally and captured on en; when nothing valid is
// selected the combinational output falls back to the held value instead of
// relying on an implicit latch. Also tracks sticky select errors and how
// many cycles the held value has aged.
module operand_sel_reg
  import cpu_pkg::*;
#(
  parameter int WIDTH  = DATA_W,
  parameter int NUM_IN = 5,
  parameter int STRICT = SEL_PRIORITY,
  parameter int AGE_W  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_IN*WIDTH-1:0]   in_flat,
  input  logic [NUM_IN-1:0]         sel,
  input  logic                      en,
  input  logic                      clr_err,
  output logic [WIDTH-1:0]          out_comb,
  output logic [WIDTH-1:0]          out_q,
  output logic                      out_vld,
  output logic [$clog2(NUM_IN)-1:0] sel_idx,
  output logic [AGE_W-1:0]          age,
  output logic                      err_multi,
  output logic                      err_none
);

  localparam int IDX_W = $clog2(NUM_IN);
  localparam sel_policy_e POLICY = (STRICT == SEL_STRICT) ? POL_STRICT : POL_PRIORITY;

  // Age counter increment that sticks at all-ones rather than wrapping.
  function automatic logic [AGE_W-1:0] age_sat_inc(input logic [AGE_W-1:0] a);
    return (&a) ? a : a + AGE_W'(1);
  endfunction

  logic [WIDTH-1:0] src [NUM_IN];
  logic [IDX_W-1:0] idx;
  logic             hit;
  logic             multi;
  logic             pass;
  logic             cap;

  for (genvar k = 0; k < NUM_IN; k++) begin : g_src
    assign src[k] = in_flat[k*WIDTH +: WIDTH];
  end

  onehot_prio_enc #(.N(NUM_IN)) u_enc (
    .sel   (sel),
    .idx   (idx),
    .hit   (hit),
    .multi (multi)
  );

  // A select is usable when something is selected and, under the strict
  // policy, exactly one thing is selected.
  assign pass     = hit && ((POLICY == POL_PRIORITY) || !multi);
  assign cap      = en && pass;
  assign out_comb = pass ? src[idx] : out_q;

  // Hold register, capture index, age and sticky error flags; reset beats en.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q     <= '0;
      sel_idx   <= '0;
      out_vld   <= 1'b0;
      age       <= '0;
      err_multi <= 1'b0;
      err_none  <= 1'b0;
    end else begin
      if (cap) begin
        out_q   <= src[idx];
        sel_idx <= idx;
        out_vld <= 1'b1;
        age     <= '0;
      end else begin
        age     <= age_sat_inc(age);
      end
      // A new error in the same cycle as clr_err keeps the flag set.
      err_multi <= (err_multi && !clr_err) || (en && multi);
      err_none  <= (err_none  && !clr_err) || (en && !hit);
    end
  end

endmodule

// File: tb/tb_operand_sel_reg.sv
// Directed bench for operand_sel_reg: priority and strict instances share
// stimulus, plus a narrow two-input instance.
module tb_operand_sel_reg;

  logic         clk = 1'b0;
  logic         rst;
  logic [159:0] in_flat;
  logic [4:0]   sel;
  logic         en;
  logic         clr_err;

  logic [31:0]  oc0, oq0, oc1, oq1;
  logic         vld0, vld1, em0, em1, en0, en1;
  logic [2:0]   idx0, idx1;
  logic [3:0]   age0, age1;

  logic [9:0]   in_flat2;
  logic [1:0]   sel2;
  logic         en2;
  logic [4:0]   oc2, oq2;
  logic         vld2, em2, enn2;
  logic         idx2;
  logic [3:0]   age2;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  operand_sel_reg #(.WIDTH(32), .NUM_IN(5), .STRICT(0), .AGE_W(4)) dut0 (
    .clk(clk), .rst(rst), .in_flat(in_flat), .sel(sel), .en(en), .clr_err(clr_err),
    .out_comb(oc0), .out_q(oq0), .out_vld(vld0), .sel_idx(idx0), .age(age0),
    .err_multi(em0), .err_none(en0));

  operand_sel_reg #(.WIDTH(32), .NUM_IN(5), .STRICT(1), .AGE_W(4)) dut1 (
    .clk(clk), .rst(rst), .in_flat(in_flat), .sel(sel), .en(en), .clr_err(clr_err),
    .out_comb(oc1), .out_q(oq1), .out_vld(vld1), .sel_idx(idx1), .age(age1),
    .err_multi(em1), .err_none(en1));

  operand_sel_reg #(.WIDTH(5), .NUM_IN(2), .STRICT(0), .AGE_W(4)) dut2 (
    .clk(clk), .rst(rst), .in_flat(in_flat2), .sel(sel2), .en(en2), .clr_err(clr_err),
    .out_comb(oc2), .out_q(oq2), .out_vld(vld2), .sel_idx(idx2), .age(age2),
    .err_multi(em2), .err_none(enn2));

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, want 'h%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst      = 1'b1;
    en       = 1'b0;
    sel      = 5'b0;
    clr_err  = 1'b0;
    en2      = 1'b0;
    sel2     = 2'b0;
    in_flat  = {32'h0000_0004, 32'h0000_0033, 32'hDEAD_BEEF, 32'h0000_0001, 32'h0000_00A0};
    in_flat2 = {5'h15, 5'h0A};

    // Reset state
    step(); step();
    check_eq("rst out_q", oq0, 0);
    check_eq("rst out_vld", vld0, 0);
    check_eq("rst sel_idx", idx0, 0);
    check_eq("rst age", age0, 0);
    check_eq("rst errs", {em0, en0}, 0);
    check_eq("rst out_comb none", oc0, 0);
    check_eq("rst strict out_q", oq1, 0);
    check_eq("rst narrow out_q", oq2, 0);

    // Capture source 2
    rst = 1'b0; sel = 5'b00100; en = 1'b1;
    #1;
    check_eq("cap out_comb", oc0, 32'hDEAD_BEEF);
    step();
    check_eq("cap out_q", oq0, 32'hDEAD_BEEF);
    check_eq("cap sel_idx", idx0, 2);
    check_eq("cap out_vld", vld0, 1);
    check_eq("cap age", age0, 0);
    check_eq("cap strict out_q", oq1, 32'hDEAD_BEEF);

    // Hold and saturating age
    sel = 5'b0; en = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      step();
      check_eq("hold age", age0, (i > 15) ? 15 : i);
    end
    check_eq("hold out_q", oq0, 32'hDEAD_BEEF);
    check_eq("hold out_comb", oc0, 32'hDEAD_BEEF);
    check_eq("hold errs", {em0, en0}, 0);

    // Empty select with en
    en = 1'b1;
    step();
    check_eq("none err_none", en0, 1);
    check_eq("none out_q", oq0, 32'hDEAD_BEEF);
    check_eq("none age sat", age0, 15);
    clr_err = 1'b1;
    step();
    check_eq("none set wins", en0, 1);
    en = 1'b0;
    step();
    check_eq("none cleared", en0, 0);
    check_eq("none no multi", em0, 0);

    // Multi-hot select
    clr_err = 1'b0; sel = 5'b10010; en = 1'b1;
    #1;
    check_eq("multi prio out_comb", oc0, 1);
    check_eq("multi strict out_comb", oc1, 32'hDEAD_BEEF);
    step();
    check_eq("multi prio out_q", oq0, 1);
    check_eq("multi prio sel_idx", idx0, 1);
    check_eq("multi prio err", em0, 1);
    check_eq("multi prio age", age0, 0);
    check_eq("multi strict out_q", oq1, 32'hDEAD_BEEF);
    check_eq("multi strict sel_idx", idx1, 2);
    check_eq("multi strict err", em1, 1);
    check_eq("multi strict out_comb", oc1, 32'hDEAD_BEEF);
    check_eq("multi strict age", age1, 15);
    check_eq("multi no err_none", {en0, en1}, 0);

    // Errors ignored while en=0
    en = 1'b0; clr_err = 1'b1;
    step();
    check_eq("clr multi", {em0, em1}, 0);
    clr_err = 1'b0;
    step();
    check_eq("en0 multi ignored", {em0, em1}, 0);
    check_eq("en0 out_comb tracks", oc0, 1);

    // Back-to-back captures
    en = 1'b1; sel = 5'b00001;
    step();
    check_eq("b2b out_q 0", oq0, 32'h0000_00A0);
    check_eq("b2b strict out_q 0", oq1, 32'h0000_00A0);
    sel = 5'b01000;
    step();
    check_eq("b2b out_q 3", oq0, 32'h0000_0033);
    check_eq("b2b sel_idx 3", idx0, 3);

    // Reset beats a capture in the same cycle
    sel = 5'b00001; rst = 1'b1;
    step();
    check_eq("rstmid out_q", oq0, 0);
    check_eq("rstmid out_vld", vld0, 0);
    check_eq("rstmid age", age0, 0);
    check_eq("rstmid sel_idx", idx0, 0);
    check_eq("rstmid strict out_q", oq1, 0);
    rst = 1'b0; en = 1'b0; sel = 5'b0;
    step();
    check_eq("post rst age", age0, 1);
    check_eq("post rst vld", vld0, 0);

    // Narrow two-input instance
    en2 = 1'b1; sel2 = 2'b10;
    #1;
    check_eq("narrow out_comb", oc2, 5'h15);
    step();
    check_eq("narrow out_q 1", oq2, 5'h15);
    check_eq("narrow sel_idx 1", idx2, 1);
    sel2 = 2'b01;
    step();
    check_eq("narrow out_q 0", oq2, 5'h0A);
    check_eq("narrow sel_idx 0", idx2, 0);
    sel2 = 2'b11;
    step();
    check_eq("narrow multi out_q", oq2, 5'h0A);
    check_eq("narrow multi err", em2, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
